// File: rtl/mod_sched.sv
// mod_sched: ASK/FSK/PSK carrier scheduler.
// Runs a 10-bit phase accumulator through an external shared adder, paces
// baseband bits one per symbol (sym_len clocks) and drives the sine ROM
// address and the amplitude gate. Three-state control: IDLE, LOAD, RUN.
module mod_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic [9:0]  fw0,
  input  logic [9:0]  fw1,
  input  logic [15:0] sym_len,
  input  logic        start,
  input  logic        stop,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [9:0]  add_a,
  output logic [9:0]  add_b,
  input  logic [9:0]  add_sum,
  output logic [9:0]  rom_addr,
  output logic        amp_en,
  output logic        busy,
  output logic        underrun
);

  // Control states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Modulation modes
  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_ASK = 2'b01;
  localparam logic [1:0] MODE_FSK = 2'b10;
  localparam logic [1:0] MODE_PSK = 2'b11;

  // Architectural state
  logic [1:0]  state_q,     state_d;
  logic [9:0]  phase_q,     phase_d;
  logic [15:0] sym_cnt_q,   sym_cnt_d;
  logic        cur_bit_q,   cur_bit_d;
  logic        stop_pend_q, stop_pend_d;
  logic [1:0]  mode_q,      mode_d;
  logic        underrun_q,  underrun_d;

  // Derived control
  logic        in_run;
  logic        in_load;
  logic        sym_last;
  logic        stop_any;
  logic        xfer;
  logic        go_idle;
  logic        flip;
  logic [9:0]  fw_sel;
  logic [15:0] sym_reload;

  assign in_run   = (state_q == ST_RUN);
  assign in_load  = (state_q == ST_LOAD);
  assign sym_last = in_run && (sym_cnt_q == 16'd0);

  // A stop arriving in the same cycle as a decision point counts as pending,
  // so the block never accepts a bit it is about to abandon.
  assign stop_any = stop_pend_q | stop;

  // Symbol length 0 behaves as 1: reload value is max(sym_len,1)-1.
  assign sym_reload = (sym_len == 16'd0) ? 16'd0 : (sym_len - 16'd1);

  // Only FSK switches frequency on the current bit; ASK/PSK always use fw0.
  assign fw_sel = ((mode_q == MODE_FSK) && cur_bit_q) ? fw1 : fw0;

  // PSK with bit 1 reads the ROM half a turn away (180-degree offset).
  assign flip = (mode_q == MODE_PSK) && cur_bit_q;

  // Ready in LOAD and on the last symbol cycle of RUN, unless stopping.
  always_comb begin
    bit_ready = 1'b0;
    if (in_load || sym_last) begin
      bit_ready = ~stop_any;
    end
  end

  assign xfer = bit_ready & bit_valid;

  // Next-state and datapath control for the IDLE/LOAD/RUN machine.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    sym_cnt_d   = sym_cnt_q;
    cur_bit_d   = cur_bit_q;
    stop_pend_d = stop_pend_q;
    mode_d      = mode_q;
    underrun_d  = 1'b0;
    go_idle     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = 10'd0;
        // stop is meaningless here; start with mode off is dropped.
        if (start && (mode != MODE_OFF)) begin
          state_d = ST_LOAD;
          mode_d  = mode;
        end
      end

      ST_LOAD: begin
        // Phase holds; wait for a bit or a stop.
        if (stop_any) begin
          go_idle = 1'b1;
        end else if (xfer) begin
          state_d   = ST_RUN;
          cur_bit_d = bit_in;
          sym_cnt_d = sym_reload;
        end
      end

      ST_RUN: begin
        // Accumulate every RUN cycle; wrap comes from the 10-bit adder.
        phase_d = add_sum;
        if (!sym_last) begin
          sym_cnt_d = sym_cnt_q - 16'd1;
          if (stop) begin
            stop_pend_d = 1'b1;
          end
        end else if (stop_any) begin
          go_idle = 1'b1;
        end else if (xfer) begin
          // Back-to-back symbol, no gap cycle.
          cur_bit_d = bit_in;
          sym_cnt_d = sym_reload;
        end else begin
          state_d    = ST_LOAD;
          underrun_d = 1'b1;
        end
      end

      default: begin
        go_idle = 1'b1;
      end
    endcase

    // Entering IDLE returns everything to its quiescent values.
    if (go_idle) begin
      state_d     = ST_IDLE;
      phase_d     = 10'd0;
      sym_cnt_d   = 16'd0;
      cur_bit_d   = 1'b0;
      stop_pend_d = 1'b0;
      mode_d      = MODE_OFF;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= 10'd0;
      sym_cnt_q   <= 16'd0;
      cur_bit_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      mode_q      <= MODE_OFF;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sym_cnt_q   <= sym_cnt_d;
      cur_bit_q   <= cur_bit_d;
      stop_pend_q <= stop_pend_d;
      mode_q      <= mode_d;
      underrun_q  <= underrun_d;
    end
  end

  // Adder operands: phase + fw_sel while running, phase + 0 otherwise.
  assign add_a = phase_q;
  assign add_b = in_run ? fw_sel : 10'd0;

  // ROM address follows the phase register directly, so the first RUN cycle
  // shows the pre-accumulation phase.
  assign rom_addr = {phase_q[9] ^ flip, phase_q[8:0]};

  // Amplitude gate: ASK keys on the bit, FSK/PSK run at full amplitude.
  always_comb begin
    amp_en = 1'b0;
    if (in_run) begin
      amp_en = (mode_q == MODE_ASK) ? cur_bit_q : 1'b1;
    end
  end

  assign busy = (state_q != ST_IDLE);

  // Underrun is registered: it pulses in the first LOAD cycle after the
  // boundary that found no bit.
  assign underrun = underrun_q;

endmodule

// File: tb/tb_mod_sched.sv
// tb_mod_sched: directed-vector bench for mod_sched with a scoreboard.
// Each vector drives inputs and queues the expected outputs for that cycle;
// a negedge monitor pops and compares independently.
module tb_mod_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [9:0]  fw0, fw1;
  logic [15:0] sym_len;
  logic        start, stop, bit_in, bit_valid;
  logic        bit_ready;
  logic [9:0]  add_a, add_b, add_sum, rom_addr;
  logic        amp_en, busy, underrun;

  always #5 clk = ~clk;

  // External shared adder, 10-bit wrap.
  assign add_sum = add_a + add_b;

  mod_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .fw0       (fw0),
    .fw1       (fw1),
    .sym_len   (sym_len),
    .start     (start),
    .stop      (stop),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rom_addr  (rom_addr),
    .amp_en    (amp_en),
    .busy      (busy),
    .underrun  (underrun)
  );

  typedef struct {
    string      tag;
    logic       bsy;
    logic       rdy;
    logic       amp;
    logic       und;
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] rom;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      n_vec++;
      if (busy !== me.bsy || bit_ready !== me.rdy || amp_en !== me.amp ||
          underrun !== me.und || add_a !== me.a || add_b !== me.b ||
          rom_addr !== me.rom) begin
        n_miss++;
        $display("FAIL %s: got busy=%0b rdy=%0b amp=%0b und=%0b a=%0d b=%0d rom=%0d | want busy=%0b rdy=%0b amp=%0b und=%0b a=%0d b=%0d rom=%0d",
                 me.tag, busy, bit_ready, amp_en, underrun, add_a, add_b, rom_addr,
                 me.bsy, me.rdy, me.amp, me.und, me.a, me.b, me.rom);
      end else begin
        $display("vec %0d %s ok: busy=%0b rdy=%0b amp=%0b und=%0b a=%0d b=%0d rom=%0d",
                 n_vec, me.tag, busy, bit_ready, amp_en, underrun, add_a, add_b, rom_addr);
      end
    end
  end

  task automatic cfg(input logic [1:0] m, input int f0, input int f1, input int sl);
    mode    = m;
    fw0     = f0[9:0];
    fw1     = f1[9:0];
    sym_len = sl[15:0];
  endtask

  // Drive one cycle of inputs, queue that cycle's expected outputs.
  task automatic vec(input string tag,
                     input logic r, input logic st, input logic sp,
                     input logic bi, input logic bv,
                     input logic e_bsy, input logic e_rdy, input logic e_amp,
                     input logic e_und, input int e_a, input int e_b, input int e_rom);
    exp_t e;
    rst_n     = r;
    start     = st;
    stop      = sp;
    bit_in    = bi;
    bit_valid = bv;
    e.tag = tag;
    e.bsy = e_bsy;
    e.rdy = e_rdy;
    e.amp = e_amp;
    e.und = e_und;
    e.a   = e_a[9:0];
    e.b   = e_b[9:0];
    e.rom = e_rom[9:0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    cfg(2'b00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state, start with mode off, stop in IDLE.
    //   tag           r st sp bi bv  bsy rdy amp und  a    b    rom
    vec("rst",         0, 0, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("off_start",   1, 1, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("idle_stop",   1, 0, 1, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("idle",        1, 0, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);

    // FSK with wrap: phase 0,300,600,900 | 176,276,376,476.
    cfg(2'b10, 100, 300, 4);
    vec("fsk_start",   1, 1, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("fsk_load",    1, 0, 0, 1, 1,  1,  1,  0,  0,  0,   0,   0);
    vec("fsk_r0",      1, 0, 0, 0, 1,  1,  0,  1,  0,  0,   300, 0);
    vec("fsk_r1",      1, 0, 0, 0, 1,  1,  0,  1,  0,  300, 300, 300);
    vec("fsk_r2",      1, 0, 0, 0, 1,  1,  0,  1,  0,  600, 300, 600);
    vec("fsk_r3",      1, 0, 0, 0, 1,  1,  1,  1,  0,  900, 300, 900);
    vec("fsk_r4",      1, 0, 1, 0, 0,  1,  0,  1,  0,  176, 100, 176);
    vec("fsk_r5",      1, 0, 0, 0, 0,  1,  0,  1,  0,  276, 100, 276);
    vec("fsk_r6",      1, 0, 0, 0, 0,  1,  0,  1,  0,  376, 100, 376);
    vec("fsk_r7",      1, 0, 0, 0, 0,  1,  0,  1,  0,  476, 100, 476);
    vec("fsk_end",     1, 0, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);

    // PSK: phase runs 0,256,512,768; the bit-1 flip maps 512,768 to 0,256.
    cfg(2'b11, 256, 5, 2);
    vec("psk_start",   1, 1, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("psk_load",    1, 0, 0, 0, 1,  1,  1,  0,  0,  0,   0,   0);
    vec("psk_r0",      1, 0, 0, 1, 1,  1,  0,  1,  0,  0,   256, 0);
    vec("psk_r1",      1, 0, 0, 1, 1,  1,  1,  1,  0,  256, 256, 256);
    vec("psk_r2",      1, 0, 1, 0, 0,  1,  0,  1,  0,  512, 256, 0);
    vec("psk_r3",      1, 0, 0, 0, 0,  1,  0,  1,  0,  768, 256, 256);
    vec("psk_end",     1, 0, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);

    // ASK underrun: boundary with no bit -> LOAD, phase held at 150.
    cfg(2'b01, 50, 0, 3);
    vec("und_start",   1, 1, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("und_load",    1, 0, 0, 1, 1,  1,  1,  0,  0,  0,   0,   0);
    vec("und_r0",      1, 0, 0, 0, 0,  1,  0,  1,  0,  0,   50,  0);
    vec("und_r1",      1, 0, 0, 0, 0,  1,  0,  1,  0,  50,  50,  50);
    vec("und_r2",      1, 0, 0, 0, 0,  1,  1,  1,  0,  100, 50,  100);
    vec("und_pulse",   1, 0, 0, 0, 0,  1,  1,  0,  1,  150, 0,   150);
    vec("und_hold",    1, 0, 0, 0, 0,  1,  1,  0,  0,  150, 0,   150);
    vec("und_refill",  1, 0, 0, 1, 1,  1,  1,  0,  0,  150, 0,   150);
    vec("und_r3",      1, 0, 1, 0, 0,  1,  0,  1,  0,  150, 50,  150);
    vec("und_r4",      1, 0, 0, 0, 0,  1,  0,  1,  0,  200, 50,  200);
    vec("und_r5",      1, 0, 0, 0, 0,  1,  0,  1,  0,  250, 50,  250);
    vec("und_end",     1, 0, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);

    // Stop at cycle 2 of a 5-cycle symbol; start while busy ignored;
    // stop in LOAD aborts without a transfer.
    cfg(2'b01, 10, 0, 5);
    vec("stp_start",   1, 1, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("stp_load",    1, 0, 0, 1, 1,  1,  1,  0,  0,  0,   0,   0);
    vec("stp_r0",      1, 0, 0, 0, 1,  1,  0,  1,  0,  0,   10,  0);
    vec("stp_r1",      1, 0, 1, 0, 1,  1,  0,  1,  0,  10,  10,  10);
    vec("stp_r2",      1, 1, 0, 0, 1,  1,  0,  1,  0,  20,  10,  20);
    vec("stp_r3",      1, 0, 0, 0, 1,  1,  0,  1,  0,  30,  10,  30);
    vec("stp_r4",      1, 0, 0, 0, 1,  1,  0,  1,  0,  40,  10,  40);
    vec("stp_idle",    1, 0, 0, 0, 1,  0,  0,  0,  0,  0,   0,   0);
    vec("stp_start2",  1, 1, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("stp_loadstp", 1, 0, 1, 1, 1,  1,  0,  0,  0,  0,   0,   0);
    vec("stp_end",     1, 0, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);

    // Reset mid-RUN at phase 700, then a mode-off start stays idle.
    cfg(2'b10, 350, 9, 8);
    vec("rr_start",    1, 1, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("rr_load",     1, 0, 0, 0, 1,  1,  1,  0,  0,  0,   0,   0);
    vec("rr_r0",       1, 0, 0, 0, 0,  1,  0,  1,  0,  0,   350, 0);
    vec("rr_r1",       1, 0, 0, 0, 0,  1,  0,  1,  0,  350, 350, 350);
    vec("rr_rst",      0, 0, 0, 0, 0,  1,  0,  1,  0,  700, 350, 700);
    cfg(2'b00, 350, 9, 8);
    vec("rr_after",    1, 1, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("rr_idle",     1, 0, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("rr_idle2",    1, 0, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);

    // sym_len=0: one RUN cycle per bit, ready every RUN cycle.
    cfg(2'b01, 7, 0, 0);
    vec("z_start",     1, 1, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);
    vec("z_load",      1, 0, 0, 1, 1,  1,  1,  0,  0,  0,   0,   0);
    vec("z_r0",        1, 0, 0, 0, 1,  1,  1,  1,  0,  0,   7,   0);
    vec("z_r1",        1, 0, 0, 1, 1,  1,  1,  0,  0,  7,   7,   7);
    vec("z_r2",        1, 0, 1, 0, 1,  1,  0,  1,  0,  14,  7,   14);
    vec("z_end",       1, 0, 0, 0, 0,  0,  0,  0,  0,  0,   0,   0);

    // Drain: bounded wait for the monitor to consume every expectation.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
